// File: rtl/mxn_shift_lane_packer_pkg.sv
// Shared definitions for the lane packer and the shift-word legality checker:
// shift-word field positions, direction encodings, amount limits, FSM encoding.
package mxn_shift_lane_packer_pkg;

  localparam int AMT_LO  = 1;
  localparam int DIR_BIT = 0;

  localparam logic DIR0 = 1'b0;
  localparam logic DIR1 = 1'b1;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  function automatic int fill_bit(input int width);
    return width - 1;
  endfunction

  function automatic int amt_hi(input int width);
    return width - 2;
  endfunction

  function automatic int max_amt_dir0(input int width);
    return width - 1;
  endfunction

  function automatic int max_amt_dir1(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/mxn_shift_lane_packer_shift_ctrl_check.sv
// Combinational legality check of one shift-control word; an illegal word is
// replaced by all-zero so the shifter never sees an out-of-range amount.
module shift_ctrl_check
  import mxn_shift_lane_packer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_shift,
  output logic             o_legal,
  output logic [WIDTH-1:0] o_word
);

  localparam int AMT_HI = amt_hi(WIDTH);
  localparam int AMT_W  = AMT_HI - AMT_LO + 1;

  // One spare MSB keeps the compare from degenerating when the limit is all-ones.
  localparam logic [AMT_W:0] MAX_DIR0 = (AMT_W+1)'(max_amt_dir0(WIDTH));
  localparam logic [AMT_W:0] MAX_DIR1 = (AMT_W+1)'(max_amt_dir1(WIDTH));

  logic [AMT_W:0] w_amt;
  logic           w_dir;

  assign w_amt = {1'b0, i_shift[AMT_HI:AMT_LO]};
  assign w_dir = i_shift[DIR_BIT];

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    o_legal = 1'b0;
    o_word  = '0;
    if (w_dir == DIR1) o_legal = (w_amt <= MAX_DIR1);
    else               o_legal = (w_amt <= MAX_DIR0);
    if (o_legal) o_word = i_shift;
  end

endmodule

// File: rtl/mxn_shift_lane_packer.sv
// Collects one lane per beat into packed operand/shift vectors and hands the
// group to the shifter array; HOLD with pack_ready passes straight into a new group.
module mxn_shift_lane_packer
  import mxn_shift_lane_packer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SETS  = 2,
  localparam int CW   = $clog2(SETS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [WIDTH-1:0]      in_shift,
  input  logic                  in_last,
  input  logic                  flush,
  output logic                  pack_valid,
  input  logic                  pack_ready,
  output logic [SETS*WIDTH-1:0] in_packed,
  output logic [SETS*WIDTH-1:0] shift_packed,
  output logic [CW-1:0]         pack_lanes,
  output logic [SETS-1:0]       illegal_packed
);

  logic [0:0]            r_state;
  logic [CW-1:0]         r_count;
  logic [SETS*WIDTH-1:0] r_data;
  logic [SETS*WIDTH-1:0] r_shift;
  logic [SETS-1:0]       r_illegal;

  logic                  w_accept;
  logic                  w_new_group;
  logic [CW-1:0]         w_lane;
  logic                  w_close;
  logic                  w_legal;
  logic [WIDTH-1:0]      w_shift_clean;

  shift_ctrl_check #(.WIDTH(WIDTH)) u_check (
    .i_shift (in_shift),
    .o_legal (w_legal),
    .o_word  (w_shift_clean)
  );

  assign in_ready    = (r_state == ST_FILL) || pack_ready;
  assign w_accept    = in_valid && in_ready;
  // A beat taken while HOLD is draining starts the next group at lane 0.
  assign w_new_group = (r_state == ST_HOLD) || (r_count == '0);
  assign w_lane      = w_new_group ? '0 : r_count;
  assign w_close     = in_last || flush || (w_lane == CW'(SETS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the lane registers are reset too, since the outputs must read zero right after reset.
      r_state   <= ST_FILL;
      r_count   <= '0;
      r_data    <= '0;
      r_shift   <= '0;
      r_illegal <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (w_accept) begin
        r_count <= w_lane + CW'(1);
        r_state <= w_close ? ST_HOLD : ST_FILL;
        for (int i = 0; i < SETS; i++) begin
          if (int'(w_lane) == i) begin
            r_data[i*WIDTH +: WIDTH]  <= in_data;
            r_shift[i*WIDTH +: WIDTH] <= w_shift_clean;
            r_illegal[i]              <= !w_legal;
          end else if (w_new_group) begin
            r_data[i*WIDTH +: WIDTH]  <= '0;
            r_shift[i*WIDTH +: WIDTH] <= '0;
            r_illegal[i]              <= 1'b0;
          end
        end
      end else if (r_state == ST_FILL) begin
        if (flush && (r_count != '0)) r_state <= ST_HOLD;
      end else if (pack_ready) begin
        r_state <= ST_FILL;
        r_count <= '0;
      end
    end
  end

  assign pack_valid     = (r_state == ST_HOLD);
  assign pack_lanes     = pack_valid ? r_count : '0;
  assign in_packed      = r_data;
  assign shift_packed   = r_shift;
  assign illegal_packed = r_illegal;

endmodule

// File: tb/tb_mxn_shift_lane_packer.sv
// Directed bench for the lane packer: a bench-side model pushes expected groups
// into a scoreboard and a negedge monitor pops them on each pack handshake.
module tb_mxn_shift_lane_packer;

  localparam int WIDTH = 4;
  localparam int SETS  = 2;
  localparam int CW    = $clog2(SETS + 1);

  typedef struct {
    logic [SETS*WIDTH-1:0] data;
    logic [SETS*WIDTH-1:0] shift;
    logic [CW-1:0]         lanes;
    logic [SETS-1:0]       illegal;
  } group_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid, in_ready, in_last, flush;
  logic [WIDTH-1:0]      in_data, in_shift;
  logic                  pack_valid, pack_ready;
  logic [SETS*WIDTH-1:0] in_packed, shift_packed;
  logic [CW-1:0]         pack_lanes;
  logic [SETS-1:0]       illegal_packed;

  int     total = 0;
  int     bad   = 0;
  int     pv_cycles = 0;
  int     groups_seen = 0;
  group_t sb[$];
  group_t cur;
  int     cur_n = 0;

  mxn_shift_lane_packer #(.WIDTH(WIDTH), .SETS(SETS)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_shift       (in_shift),
    .in_last        (in_last),
    .flush          (flush),
    .pack_valid     (pack_valid),
    .pack_ready     (pack_ready),
    .in_packed      (in_packed),
    .shift_packed   (shift_packed),
    .pack_lanes     (pack_lanes),
    .illegal_packed (illegal_packed)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent legality reference for WIDTH=4: dir0 any amount, dir1 amount <= 2.
  function automatic logic tb_legal(input logic [WIDTH-1:0] s);
    if (s[0]) return (s[2:1] <= 2'd2);
    return 1'b1;
  endfunction

  function automatic group_t empty_group();
    group_t g;
    g.data = '0; g.shift = '0; g.lanes = '0; g.illegal = '0;
    return g;
  endfunction

  task automatic model_accept(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] s, input logic close);
    logic ok;
    ok = tb_legal(s);
    cur.data[cur_n*WIDTH +: WIDTH]  = d;
    cur.shift[cur_n*WIDTH +: WIDTH] = ok ? s : '0;
    cur.illegal[cur_n]              = !ok;
    cur_n++;
    if (close || cur_n == SETS) begin
      cur.lanes = CW'(cur_n);
      sb.push_back(cur);
      cur = empty_group();
      cur_n = 0;
    end
  endtask

  task automatic beat(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] s, input logic last);
    int waited = 0;
    in_valid = 1'b1; in_data = d; in_shift = s; in_last = last;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    check("beat_in_ready", 32'(in_ready), 32'd1);
    model_accept(d, s, last || flush);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    if (cur_n > 0) begin
      cur.lanes = CW'(cur_n);
      sb.push_back(cur);
      cur = empty_group();
      cur_n = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && pack_valid) begin
      pv_cycles++;
      if (pack_ready) begin
        group_t g;
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          g = sb.pop_front();
          groups_seen++;
          check("grp_data",    32'(in_packed),      32'(g.data));
          check("grp_shift",   32'(shift_packed),   32'(g.shift));
          check("grp_lanes",   32'(pack_lanes),     32'(g.lanes));
          check("grp_illegal", 32'(illegal_packed), 32'(g.illegal));
        end
      end
    end
  end

  initial begin
    int pv0, g0;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; flush = 1'b0;
    in_data = '0; in_shift = '0; pack_ready = 1'b1;
    cur = empty_group();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_pack_valid", 32'(pack_valid), 32'd0);
    check("rst_in_packed",  32'(in_packed),  32'd0);
    check("rst_lanes",      32'(pack_lanes), 32'd0);
    check("rst_in_ready",   32'(in_ready),   32'd1);
    @(posedge clk); #1;

    // Reset mid-group discards the partial lane.
    beat(4'h1, 4'h7, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_pack_valid", 32'(pack_valid),     32'd0);
    check("midrst_in_packed",  32'(in_packed),      32'd0);
    check("midrst_shift",      32'(shift_packed),   32'd0);
    check("midrst_illegal",    32'(illegal_packed), 32'd0);
    sb.delete();
    cur = empty_group();
    cur_n = 0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Full group, 1-cycle latency from closing beat.
    beat(4'h5, 4'hC, 1'b0);
    check("half_no_valid", 32'(pack_valid), 32'd0);
    beat(4'hA, 4'h3, 1'b0);
    check("full_latency_valid", 32'(pack_valid), 32'd1);
    check("full_in_packed",     32'(in_packed),  32'hA5);
    check("full_shift",         32'(shift_packed), 32'h3C);
    @(posedge clk); #1;

    // Illegal word on lane 0, held under back-pressure.
    pack_ready = 1'b0;
    beat(4'h9, 4'h7, 1'b0);
    beat(4'h1, 4'h6, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid",    32'(pack_valid),     32'd1);
      check("bp_in_ready", 32'(in_ready),       32'd0);
      check("bp_data",     32'(in_packed),      32'h19);
      check("bp_shift",    32'(shift_packed),   32'h60);
      check("bp_illegal",  32'(illegal_packed), 32'h1);
      check("bp_lanes",    32'(pack_lanes),     32'd2);
    end
    @(posedge clk); #1;
    pack_ready = 1'b1;
    beat(4'h7, 4'h0, 1'b0);
    check("pass_new_fill",  32'(pack_valid), 32'd0);
    check("pass_new_lane0", 32'(in_packed),  32'h07);
    do_flush();
    check("flush_valid", 32'(pack_valid), 32'd1);
    @(posedge clk); #1;

    // Partial groups: in_last, then beat followed by flush.
    beat(4'h3, 4'h2, 1'b1);
    check("last_lanes", 32'(pack_lanes), 32'd1);
    @(posedge clk); #1;
    beat(4'h3, 4'h2, 1'b0);
    do_flush();
    check("flush2_lanes", 32'(pack_lanes), 32'd1);
    check("flush2_data",  32'(in_packed),  32'h03);
    repeat (2) @(posedge clk); #1;

    // Flush with no lanes and in_last without in_valid do nothing.
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_last = 1'b1;
    @(posedge clk); #1;
    in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_no_valid", 32'(pack_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Continuous stream of 8 beats -> exactly 4 groups.
    pv0 = pv_cycles;
    g0  = groups_seen;
    for (int i = 0; i < 8; i++) beat(4'(i + 8), 4'(i), 1'b0);
    repeat (3) @(negedge clk);
    check("stream_pv_cycles", 32'(pv_cycles - pv0),   32'd4);
    check("stream_groups",    32'(groups_seen - g0),  32'd4);
    check("sb_drained",       32'(sb.size()),         32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
